// File: rtl/noc_router_xy.sv
// -----------------------------------------------------------------------------
// noc_router_xy
//
// Five-port XY-routed mesh router for one tile of a ROWS x COLS mesh.
// Every input port has its own FIFO. Every output port has a round-robin
// arbiter that feeds a registered output stage. All links use valid/ready
// handshakes. Flits are never dropped, except as described under the optional
// range check below. When two flits collide, the loser stays in its FIFO, and
// a full FIFO then stalls its upstream neighbour.
//
// Port index on every packed bus: 0 = Local, 1 = North, 2 = South,
// 3 = East, 4 = West. Port p occupies bits [p*FW +: FW].
// Flit layout (MSB first): dest_row, dest_col, payload.
//
// Ports:
//   clk            single clock
//   rst            synchronous, active-high reset
//   in_flit        5 packed input flits
//   in_valid       per-port input valid
//   in_ready       per-port input ready (FIFO not full, low during reset)
//   out_flit       5 packed output flits (registered)
//   out_valid      per-port output valid (registered)
//   out_ready      per-port output ready from downstream
//   err_unroutable pulses when an out-of-range flit is discarded
//
// Build option:
//   NOC_ROUTER_RANGE_CHECK_EN - when defined, a FIFO head whose dest_row is
//   >= ROWS, or whose dest_col is >= COLS, is discarded without requesting
//   any output, and err_unroutable pulses for that cycle. When undefined,
//   such flits follow the plain XY comparisons and err_unroutable is 0.
// -----------------------------------------------------------------------------
module noc_router_xy #(
  parameter int ROWS       = 2,
  parameter int COLS       = 2,
  parameter int MY_ROW     = 0,
  parameter int MY_COL     = 0,
  parameter int COORD_W    = 2,
  parameter int PAYLOAD_W  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [5*(2*COORD_W+PAYLOAD_W)-1:0]    in_flit,
  input  logic [4:0]                            in_valid,
  output logic [4:0]                            in_ready,
  output logic [5*(2*COORD_W+PAYLOAD_W)-1:0]    out_flit,
  output logic [4:0]                            out_valid,
  input  logic [4:0]                            out_ready,
  output logic                                  err_unroutable
);

  localparam int FW = 2*COORD_W + PAYLOAD_W;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] PORT_L = 3'd0;
  localparam logic [2:0] PORT_N = 3'd1;
  localparam logic [2:0] PORT_S = 3'd2;
  localparam logic [2:0] PORT_E = 3'd3;
  localparam logic [2:0] PORT_W = 3'd4;

  localparam logic [COORD_W-1:0] MY_ROW_C = COORD_W'(MY_ROW);
  localparam logic [COORD_W-1:0] MY_COL_C = COORD_W'(MY_COL);
  localparam logic [AW:0]        PTR_ONE  = (AW+1)'(1);

  // Stop elaboration on configurations the addressing cannot support.
  if ((2**COORD_W) < ROWS || (2**COORD_W) < COLS) begin : g_bad_coord_w
    $error("noc_router_xy: COORD_W too narrow for ROWS/COLS");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0) begin : g_bad_depth
    $error("noc_router_xy: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  logic [FW-1:0]      mem [5][FIFO_DEPTH];
  logic [AW:0]        wr_ptr [5];
  logic [AW:0]        rd_ptr [5];
  logic [4:0]         empty;
  logic [4:0]         full;
  logic [4:0]         push;
  logic [4:0]         pop;
  logic [4:0]         drop;
  logic [FW-1:0]      head [5];
  logic [COORD_W-1:0] dest_row [5];
  logic [COORD_W-1:0] dest_col [5];
  logic [2:0]         route [5];
  logic [4:0]         req [5];
  logic [4:0]         free;
  logic [4:0]         grant_valid;
  logic [2:0]         grant_idx [5];
  logic [2:0]         rr_ptr [5];

  // FIFO status and head decode. The pointers carry one extra wrap bit, so
  // "full" means the pointers differ only in that top bit.
  always_comb begin
    for (int p = 0; p < 5; p++) begin
      empty[p]    = (wr_ptr[p] == rd_ptr[p]);
      full[p]     = (wr_ptr[p][AW] != rd_ptr[p][AW]) &&
                    (wr_ptr[p][AW-1:0] == rd_ptr[p][AW-1:0]);
      head[p]     = mem[p][rd_ptr[p][AW-1:0]];
      dest_row[p] = head[p][FW-1 -: COORD_W];
      dest_col[p] = head[p][FW-COORD_W-1 -: COORD_W];
    end
  end

  // Ready depends only on stored pointer state (and reset), never on out_ready.
  assign in_ready = ~full & {5{~rst}};
  assign push     = in_valid & in_ready;

  // Dimension-ordered routing: resolve the column first, then the row.
  always_comb begin
    for (int p = 0; p < 5; p++) begin
      if (dest_col[p] > MY_COL_C)      route[p] = PORT_E;
      else if (dest_col[p] < MY_COL_C) route[p] = PORT_W;
      else if (dest_row[p] > MY_ROW_C) route[p] = PORT_S;
      else if (dest_row[p] < MY_ROW_C) route[p] = PORT_N;
      else                             route[p] = PORT_L;
    end
  end

`ifdef NOC_ROUTER_RANGE_CHECK_EN
  localparam logic [COORD_W:0] ROWS_C = (COORD_W+1)'(ROWS);
  localparam logic [COORD_W:0] COLS_C = (COORD_W+1)'(COLS);

  // An out-of-range head is discarded on its own, without requesting an output.
  always_comb begin
    for (int p = 0; p < 5; p++) begin
      drop[p] = !empty[p] && (({1'b0, dest_row[p]} >= ROWS_C) ||
                              ({1'b0, dest_col[p]} >= COLS_C));
    end
  end
  // No pop happens during reset, so the pulse is suppressed while rst is high.
  assign err_unroutable = (|drop) & ~rst;
`else
  assign drop           = '0;
  assign err_unroutable = 1'b0;
`endif

  // Request matrix: req[o][p] means input p's head wants output o.
  always_comb begin
    for (int o = 0; o < 5; o++) begin
      free[o] = !out_valid[o] || out_ready[o];
      for (int p = 0; p < 5; p++) begin
        req[o][p] = !empty[p] && !drop[p] && (route[p] == 3'(o));
      end
    end
  end

  // Round-robin pick per output. The search starts at rr_ptr and wraps
  // modulo 5, so a 4-bit candidate index is needed before the wrap.
  always_comb begin
    logic [3:0] cand;
    cand = '0;
    for (int o = 0; o < 5; o++) begin
      grant_valid[o] = 1'b0;
      grant_idx[o]   = 3'd0;
      for (int i = 0; i < 5; i++) begin
        cand = {1'b0, rr_ptr[o]} + 4'(i);
        if (cand >= 4'd5) cand = cand - 4'd5;
        if (free[o] && !grant_valid[o] && req[o][cand[2:0]]) begin
          grant_valid[o] = 1'b1;
          grant_idx[o]   = cand[2:0];
        end
      end
    end
  end

  // Each FIFO requests at most one output, so at most one grant can pop it.
  always_comb begin
    pop = drop;
    for (int o = 0; o < 5; o++) begin
      if (grant_valid[o]) pop[grant_idx[o]] = 1'b1;
    end
  end

  // FIFO pointers. A push and a pop in the same cycle leave occupancy unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 5; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 5; p++) begin
        if (push[p]) wr_ptr[p] <= wr_ptr[p] + PTR_ONE;
        if (pop[p])  rd_ptr[p] <= rd_ptr[p] + PTR_ONE;
      end
    end
  end

  // FIFO storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 5; p++) begin
      if (push[p]) mem[p][wr_ptr[p][AW-1:0]] <= in_flit[p*FW +: FW];
    end
  end

  // Output registers. A stage reloads only when free, so data holds stable
  // until downstream accepts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      out_flit  <= '0;
      for (int o = 0; o < 5; o++) rr_ptr[o] <= 3'd0;
    end else begin
      for (int o = 0; o < 5; o++) begin
        if (free[o]) begin
          if (grant_valid[o]) begin
            out_valid[o]          <= 1'b1;
            out_flit[o*FW +: FW]  <= head[grant_idx[o]];
            rr_ptr[o]             <= (grant_idx[o] == 3'd4) ? 3'd0 : grant_idx[o] + 3'd1;
          end else begin
            out_valid[o] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_router_xy.sv
// -----------------------------------------------------------------------------
// tb_noc_router_xy
//
// Self-checking bench for noc_router_xy. The router sits at tile (1,1) of a
// 3x3 mesh, so every output direction is reachable and coordinate value 3 is
// out of range. A queue-based reference model follows the routing and
// arbitration rules and is compared against the DUT every cycle. Directed
// sections pin the model with hand-computed literals. The range-check
// expectations follow NOC_ROUTER_RANGE_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_noc_router_xy;

  localparam int ROWS = 3, COLS = 3, MY_ROW = 1, MY_COL = 1;
  localparam int COORD_W = 2, PAYLOAD_W = 8, DEPTH = 4;
  localparam int FW = 2*COORD_W + PAYLOAD_W;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [5*FW-1:0] in_flit = '0;
  logic [4:0]      in_valid = '0;
  logic [4:0]      in_ready;
  logic [5*FW-1:0] out_flit;
  logic [4:0]      out_valid;
  logic [4:0]      out_ready = 5'h1F;
  logic            err_unroutable;

  noc_router_xy #(
    .ROWS(ROWS), .COLS(COLS), .MY_ROW(MY_ROW), .MY_COL(MY_COL),
    .COORD_W(COORD_W), .PAYLOAD_W(PAYLOAD_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
    .err_unroutable(err_unroutable)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  // Reference model: input buffers as queues, plus output stage contents.
  logic [FW-1:0] m_q [5][$];
  logic [4:0]    m_ov = '0;
  logic [FW-1:0] m_of [5];
  int            m_rr [5];

  function automatic logic [FW-1:0] mk(int r, int c, int pay);
    return {COORD_W'(r), COORD_W'(c), PAYLOAD_W'(pay)};
  endfunction

  function automatic logic [5*FW-1:0] slot(int p, logic [FW-1:0] f);
    logic [5*FW-1:0] v;
    v = '0;
    v[p*FW +: FW] = f;
    return v;
  endfunction

  function automatic int routeOf(logic [FW-1:0] f);
    int r, c;
    r = int'(f[FW-1 -: COORD_W]);
    c = int'(f[FW-COORD_W-1 -: COORD_W]);
    if (c > MY_COL) return 3;
    if (c < MY_COL) return 4;
    if (r > MY_ROW) return 2;
    if (r < MY_ROW) return 1;
    return 0;
  endfunction

  function automatic bit outOfRange(logic [FW-1:0] f);
`ifdef NOC_ROUTER_RANGE_CHECK_EN
    return (int'(f[FW-1 -: COORD_W]) >= ROWS) || (int'(f[FW-COORD_W-1 -: COORD_W]) >= COLS);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit modelErr();
    bit e;
    e = 1'b0;
    for (int p = 0; p < 5; p++)
      if (m_q[p].size() > 0 && outOfRange(m_q[p][0])) e = 1'b1;
    return e && !rst;
  endfunction

  // One clock edge of the model, using the inputs as they stood before the edge.
  task automatic modelStep();
    bit acc[5];
    bit rm[5];
    int g, p;
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        m_q[i].delete();
        m_of[i] = '0;
        m_rr[i] = 0;
      end
      m_ov = '0;
      return;
    end
    for (int i = 0; i < 5; i++) begin
      acc[i] = in_valid[i] && (m_q[i].size() < DEPTH);
      rm[i]  = (m_q[i].size() > 0) && outOfRange(m_q[i][0]);
    end
    for (int o = 0; o < 5; o++) begin
      if (!m_ov[o] || out_ready[o]) begin
        g = -1;
        for (int k = 0; k < 5; k++) begin
          p = (m_rr[o] + k) % 5;
          if (g < 0 && m_q[p].size() > 0 && !outOfRange(m_q[p][0]) && routeOf(m_q[p][0]) == o)
            g = p;
        end
        if (g >= 0) begin
          m_of[o] = m_q[g][0];
          m_ov[o] = 1'b1;
          m_rr[o] = (g + 1) % 5;
          rm[g]   = 1'b1;
        end else begin
          m_ov[o] = 1'b0;
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (rm[i])  void'(m_q[i].pop_front());
      if (acc[i]) m_q[i].push_back(in_flit[i*FW +: FW]);
    end
  endtask

  task automatic checkValue(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    logic [4:0]      exp_rdy;
    logic [5*FW-1:0] mask, exp_flit;
    mask = '0;
    exp_flit = '0;
    for (int p = 0; p < 5; p++) exp_rdy[p] = !rst && (m_q[p].size() < DEPTH);
    for (int o = 0; o < 5; o++) begin
      if (m_ov[o]) begin
        mask[o*FW +: FW]     = '1;
        exp_flit[o*FW +: FW] = m_of[o];
      end
    end
    checkValue("model in_ready", 64'(in_ready), 64'(exp_rdy));
    checkValue("model out_valid", 64'(out_valid), 64'(m_ov));
    checkValue("model out_flit", 64'(out_flit & mask), 64'(exp_flit));
    checkValue("model err_unroutable", 64'(err_unroutable), 64'(modelErr()));
  endtask

  always @(posedge clk) modelStep();
  always @(negedge clk) if (check_en) checkOutput();

  // Drive one cycle of inputs, then return 1 ns after the edge that consumed them.
  task automatic applyStimulus(input logic [4:0] v, input logic [5*FW-1:0] f,
                               input logic [4:0] ordy);
    in_valid  = v;
    in_flit   = f;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0]      rv, ro;
    logic [5*FW-1:0] rf;

    $display("[TB] reset");
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkValue("reset in_ready", 64'(in_ready), 64'h0);
    checkValue("reset out_valid", 64'(out_valid), 64'h0);
    checkValue("reset err", 64'(err_unroutable), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(5'h00, '0, 5'h1F);
      checkValue("idle in_ready", 64'(in_ready), 64'h1F);
      checkValue("idle out_valid", 64'(out_valid), 64'h0);
      checkValue("idle out_flit", 64'(out_flit), 64'h0);
    end

    $display("[TB] basic routing");
    applyStimulus(5'b00001, slot(0, mk(1, 2, 8'hA5)), 5'h1F);
    applyStimulus(5'b00000, '0, 5'h1F);
    checkValue("L->E valid", 64'(out_valid), 64'b01000);
    checkValue("L->E flit", 64'(out_flit[3*FW +: FW]), 64'h6A5);
    applyStimulus(5'b00001, slot(0, mk(2, 1, 8'hA5)), 5'h1F);
    applyStimulus(5'b00000, '0, 5'h1F);
    checkValue("L->S valid", 64'(out_valid), 64'b00100);
    checkValue("L->S flit", 64'(out_flit[2*FW +: FW]), 64'h9A5);
    applyStimulus(5'b00001, slot(0, mk(1, 1, 8'hA5)), 5'h1F);
    applyStimulus(5'b00000, '0, 5'h1F);
    checkValue("L->L valid", 64'(out_valid), 64'b00001);
    checkValue("L->L flit", 64'(out_flit[0*FW +: FW]), 64'h5A5);
    applyStimulus(5'b00000, '0, 5'h1F);

    $display("[TB] round robin on E");
    applyStimulus(5'b00010, slot(1, mk(1, 2, 8'h10)), 5'h1F);
    applyStimulus(5'b00000, '0, 5'h1F);
    checkValue("N->E flit", 64'(out_flit[3*FW +: FW]), 64'h610);
    applyStimulus(5'b10110, slot(1, mk(1, 2, 8'h11)) | slot(2, mk(1, 2, 8'h22)) |
                            slot(4, mk(1, 2, 8'h44)), 5'h1F);
    applyStimulus(5'b00000, '0, 5'h1F);
    checkValue("rr 1st S", 64'({out_valid[3], out_flit[3*FW +: FW]}), 64'h1622);
    applyStimulus(5'b00000, '0, 5'h1F);
    checkValue("rr 2nd W", 64'({out_valid[3], out_flit[3*FW +: FW]}), 64'h1644);
    applyStimulus(5'b00000, '0, 5'h1F);
    checkValue("rr 3rd N", 64'({out_valid[3], out_flit[3*FW +: FW]}), 64'h1611);
    applyStimulus(5'b00000, '0, 5'h1F);
    checkValue("rr drained", 64'(out_valid), 64'h0);

    $display("[TB] backpressure on E");
    for (int i = 0; i < 5; i++)
      applyStimulus(5'b00001, slot(0, mk(1, 2, 8'hB0 + i)), 5'b10111);
    checkValue("bp in_ready full", 64'(in_ready[0]), 64'h0);
    checkValue("bp held flit", 64'({out_valid[3], out_flit[3*FW +: FW]}), 64'h16B0);
    applyStimulus(5'b00000, '0, 5'b10111);
    checkValue("bp still full", 64'(in_ready[0]), 64'h0);
    checkValue("bp still held", 64'(out_flit[3*FW +: FW]), 64'h6B0);
    applyStimulus(5'b00000, '0, 5'h1F);
    checkValue("bp ready back", 64'(in_ready[0]), 64'h1);
    checkValue("bp order 1", 64'(out_flit[3*FW +: FW]), 64'h6B1);
    for (int i = 2; i < 5; i++) begin
      applyStimulus(5'b00000, '0, 5'h1F);
      checkValue("bp order", 64'({out_valid[3], out_flit[3*FW +: FW]}), 64'(mk(1, 2, 8'hB0 + i)) | 64'h1000);
    end
    applyStimulus(5'b00000, '0, 5'h1F);
    checkValue("bp drained", 64'(out_valid), 64'h0);

    $display("[TB] streaming N->S and W->E");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(5'b10010, slot(1, mk(2, 1, i)) | slot(4, mk(1, 2, 8'h80 + i)), 5'h1F);
      if (i > 0) begin
        checkValue("stream S", 64'({out_valid[2], out_flit[2*FW +: FW]}), 64'(mk(2, 1, i - 1)) | 64'h1000);
        checkValue("stream E", 64'({out_valid[3], out_flit[3*FW +: FW]}), 64'(mk(1, 2, 8'h80 + i - 1)) | 64'h1000);
      end
    end
    applyStimulus(5'b00000, '0, 5'h1F);
    checkValue("stream S last", 64'(out_flit[2*FW +: FW]), 64'h907);
    applyStimulus(5'b00000, '0, 5'h1F);

    $display("[TB] out-of-range destination");
    applyStimulus(5'b00001, slot(0, mk(3, 1, 8'h3C)), 5'h1F);
`ifdef NOC_ROUTER_RANGE_CHECK_EN
    checkValue("range err pulse", 64'(err_unroutable), 64'h1);
    applyStimulus(5'b00000, '0, 5'h1F);
    checkValue("range err clear", 64'(err_unroutable), 64'h0);
    checkValue("range no output", 64'(out_valid), 64'h0);
`else
    checkValue("range err tied", 64'(err_unroutable), 64'h0);
    applyStimulus(5'b00000, '0, 5'h1F);
    checkValue("range exits S", 64'({out_valid, out_flit[2*FW +: FW]}), 64'h04D3C);
`endif
    applyStimulus(5'b00000, '0, 5'h1F);

    $display("[TB] random traffic");
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rv = 5'($urandom);
      ro = '0;
      rf = '0;
      for (int p = 0; p < 5; p++) begin
        rf[p*FW +: FW] = mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                            int'($urandom_range(0, 255)));
        ro[p] = ($urandom_range(0, 3) != 0);
      end
      if (cyc == 700) rst = 1'b1;
      if (cyc == 702) rst = 1'b0;
      applyStimulus(rv, rf, ro);
    end
    for (int i = 0; i < 20; i++) applyStimulus(5'b00000, '0, 5'h1F);
    checkValue("final out_valid", 64'(out_valid), 64'h0);
    checkValue("final in_ready", 64'(in_ready), 64'h1F);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_router_xy.md
Name: noc_router_xy

Overview:
- Parametrised successor of the 2x2 mesh router: one 5-port XY router for an R x C mesh with buffered, backpressured links.
- Ports are Local, North, South, East and West. Each port has a per-input FIFO and a round-robin arbiter, and each output port has a registered output stage.
- Flits are never dropped or overwritten. Collisions stall upstream through valid/ready.
- One instance sits per tile. A thin Wishbone shim (separate block) feeds the Local port.

Parameters:
- ROWS, 2, mesh rows. Row index increases southward.
- COLS, 2, mesh columns. Column index increases eastward.
- MY_ROW, 0, this tile's row.
- MY_COL, 0, this tile's column.
- COORD_W, 2, bits per destination coordinate. Must satisfy 2^COORD_W >= max(ROWS, COLS).
- PAYLOAD_W, 32, payload bits per flit.
- FIFO_DEPTH, 4, entries per input FIFO. Must be a power of 2 and >= 2.
- Derived: FW = 2*COORD_W + PAYLOAD_W.
- Flit layout: [FW-1 -: COORD_W] = dest_row, then dest_col, then payload.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- in_flit  in  5*FW  packed input flits; port p occupies [p*FW +: FW]. Port index: 0=L, 1=N, 2=S, 3=E, 4=W.
- in_valid  in  5  per-port input valid.
- in_ready  out  5  per-port input ready.
- out_flit  out  5*FW  packed output flits, same indexing.
- out_valid  out  5  per-port output valid.
- out_ready  in  5  per-port output ready.
- err_unroutable  out  1  one-cycle pulse when a flit is dropped (see Optional Feature).

Behaviour:
- Reset (synchronous): every FIFO empty; all out_valid = 0; out_flit = 0; all round-robin pointers = 0; err_unroutable = 0. in_ready is 0 while rst is high and 1 in the first cycle after.
- Input transfer: a flit transfers when in_valid[p] & in_ready[p] at a rising edge.
  - in_ready[p] = !full[p]. It is registered state only, never a combinational path from out_ready.
  - A full FIFO that pops and pushes in the same cycle still deasserts in_ready.
- Routing is XY on the FIFO head, combinational:
  - dest_col > MY_COL -> E.
  - dest_col < MY_COL -> W.
  - Otherwise, dest_row > MY_ROW -> S.
  - dest_row < MY_ROW -> N.
  - Otherwise -> L.
- Output register o:
  - It is "free" when !out_valid[o] | out_ready[o].
  - Transfer out occurs when out_valid & out_ready at a rising edge.
  - out_valid and out_flit hold stable until that transfer (standard valid/ready).
- Arbitration, per output o, each cycle:
  - Requesters are the non-empty FIFOs whose head routes to o.
  - If o is free and any requester exists, grant the first requester at or after rr_ptr[o], scanning upward modulo 5.
  - On grant: load the head into out_flit[o], set out_valid[o] = 1, pop that FIFO, and set rr_ptr[o] = granted + 1 (mod 5).
  - If o is free and nothing is granted, out_valid[o] goes to 0.
- Each FIFO requests exactly one output per cycle, so at most one pop per FIFO per cycle. Different outputs grant independently in the same cycle.
- U-turns are legal in the logic. A flit from N routed to N is forwarded as computed (cannot occur with XY on a consistent mesh).
- Latency: a flit accepted at edge k, with an empty FIFO and a free output, is visible on out_* after edge k+1. There is no combinational in->out path.
- Throughput: one flit per output per cycle under continuous out_ready.
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits; they wrap naturally.
  - Full when the pointers differ only in the MSB.
  - Simultaneous push and pop on a non-full, non-empty FIFO keeps occupancy constant.
  - Pop on empty is impossible, since empty FIFOs never request.
- Reset mid-operation: all buffered and in-flight flits are discarded. Upstream must also be reset; no recovery protocol.

Optional Feature:
- Macro: NOC_ROUTER_RANGE_CHECK_EN.
- Defined: a FIFO head with dest_row >= ROWS or dest_col >= COLS is unroutable.
  - It is popped without requesting any output.
  - err_unroutable pulses high for exactly that cycle.
  - The pop costs one cycle and does not stall other FIFOs.
- Undefined: no check; out-of-range destinations route by the XY comparison rules; err_unroutable is tied 0.

Test Plan:
- Reset, then idle: in_ready = 5'b11111, out_valid = 0, out_flit = 0 for 10 cycles.
- MY=(0,0) in a 2x2 mesh, L injects dest (0,1) payload 0xA5: out E carries {0,1,0xA5} after edge k+1. Dest (1,0) -> S. Dest (0,0) -> L.
- N, S and W all hold heads routed to E in the same cycle, out_ready[E] = 1: E emits S, W, N order starting from rr_ptr = 2 (after an earlier grant to N). No flit lost; all three delivered in 3 consecutive cycles.
- out_ready[E] = 0 while L injects 5 flits to E with FIFO_DEPTH = 4: the 1st flit is in the out register, 4 fill the FIFO, and in_ready[0] = 0 after that. Releasing out_ready gives in-order delivery and in_ready reasserts one cycle after the first pop.
- Continuous streaming N->S and W->E simultaneously, out_ready = 1: each output emits 1 flit per cycle, with no bubbles after the first.
- With NOC_ROUTER_RANGE_CHECK_EN, ROWS = 3, COORD_W = 2, inject dest_row = 3: err_unroutable pulses for 1 cycle and no out_valid rises. Without the macro, the flit exits S.
